// File: rtl/seq_muldiv_pkg.sv
// Shared types and helpers for the sequential multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MULS = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIVS = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    localparam int unsigned NEG_W = 64;
    typedef logic [NEG_W-1:0] wide_t;

    // Callers zero-extend into wide_t and truncate back; the low bits of a
    // two's-complement negation do not depend on the discarded upper bits.
    function automatic wide_t negate2c(input wide_t v);
        return ~v + wide_t'(1);
    endfunction

endpackage

// File: rtl/seq_muldiv_addsub.sv
// Combinational adder/subtractor shared by the multiply add and divide trial-subtract.
module addsub #(
    parameter int unsigned W = 9
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    output logic [W-1:0] s
);

    assign s = x + (sub ? ~y : y) + W'(sub);

endmodule

// File: rtl/seq_muldiv.sv
// Sequential signed/unsigned N x N multiplier and restoring N / N divider
// with a start/busy/done handshake and fixed N+2 cycle latency.
module seq_muldiv
    import muldiv_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = $clog2(N + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result_lo,
    output logic [N-1:0] result_hi,
    output logic         div_by_zero
);

    state_t         state, state_nx;
    op_t            op_in, op_r;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   hi, lo, m, a_raw;
    logic           sq, sr, dz;
    logic           accept, in_div, in_sgn, op_div;
    logic [N-1:0]   a_mag, b_mag;
    logic [N:0]     as_x, as_y, as_s;
    logic           as_sub;
    logic [2*N-1:0] prod_neg;
    logic [N-1:0]   quo_neg, rem_neg, fix_lo, fix_hi;

    assign op_in  = op_t'(op);
    assign in_div = (op_in == OP_DIVU) || (op_in == OP_DIVS);
    assign in_sgn = (op_in == OP_MULS) || (op_in == OP_DIVS);
    assign op_div = (op_r == OP_DIVU) || (op_r == OP_DIVS);
    assign accept = start && ((state == S_IDLE) || (state == S_DONE));

    assign a_mag = (in_sgn && a[N-1]) ? N'(negate2c(wide_t'(a))) : a;
    assign b_mag = (in_sgn && b[N-1]) ? N'(negate2c(wide_t'(b))) : b;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (cnt == '0) state_nx = S_FIX;
            S_FIX:   state_nx = S_DONE;
            S_DONE:  state_nx = start ? S_RUN : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state == S_RUN) || (state == S_FIX);
        done = (state == S_DONE);
    end

    // Multiply adds M to the upper half when the LSB is set; divide shifts
    // {rem, quo} left and trial-subtracts the divisor from the new remainder.
    always_comb begin
        if (op_div) begin
            as_x   = {hi, lo[N-1]};
            as_y   = {1'b0, m};
            as_sub = 1'b1;
        end else begin
            as_x   = {1'b0, hi};
            as_y   = lo[0] ? {1'b0, m} : '0;
            as_sub = 1'b0;
        end
    end

    addsub #(.W(N + 1)) u_addsub (
        .x   (as_x),
        .y   (as_y),
        .sub (as_sub),
        .s   (as_s)
    );

    always_comb begin
        prod_neg = (2*N)'(negate2c(wide_t'({hi, lo})));
        quo_neg  = N'(negate2c(wide_t'(lo)));
        rem_neg  = N'(negate2c(wide_t'(hi)));
        fix_lo   = lo;
        fix_hi   = hi;
        if (dz) begin
            fix_lo = '1;
            fix_hi = a_raw;
        end else if (op_div) begin
            if (sq) fix_lo = quo_neg;
            if (sr) fix_hi = rem_neg;
        end else if (sq) begin
            {fix_hi, fix_lo} = prod_neg;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            m           <= '0;
            a_raw       <= '0;
            op_r        <= OP_MULU;
            sq          <= 1'b0;
            sr          <= 1'b0;
            dz          <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                cnt   <= CW'(N - 1);
                op_r  <= op_in;
                a_raw <= a;
                sq    <= in_sgn && (a[N-1] ^ b[N-1]);
                sr    <= in_sgn && in_div && a[N-1];
                dz    <= in_div && (b == '0);
                hi    <= '0;
                m     <= in_div ? b_mag : a_mag;
                lo    <= in_div ? a_mag : b_mag;
            end else if (state == S_RUN) begin
                cnt <= cnt - 1'b1;
                if (!op_div) begin
                    hi <= as_s[N:1];
                    lo <= {as_s[0], lo[N-1:1]};
                end else if (!as_s[N]) begin
                    hi <= as_s[N-1:0];
                    lo <= {lo[N-2:0], 1'b1};
                end else begin
                    hi <= as_x[N-1:0];
                    lo <= {lo[N-2:0], 1'b0};
                end
            end else if (state == S_FIX) begin
                result_lo   <= fix_lo;
                result_hi   <= fix_hi;
                div_by_zero <= dz;
            end
        end
    end

endmodule

// File: tb/tb_seq_muldiv.sv
// Directed self-checking bench for seq_muldiv (N = 8).
module tb_seq_muldiv;

    localparam int unsigned N = 8;

    logic         osc_clk = 1'b0;
    logic         reset   = 1'b1;
    logic         start   = 1'b0;
    logic [1:0]   op      = 2'b00;
    logic [N-1:0] a       = '0;
    logic [N-1:0] b       = '0;
    logic         busy, done, div_by_zero;
    logic [N-1:0] result_lo, result_hi;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [N-1:0] last_lo = '0;
    logic [N-1:0] last_hi = '0;

    always #5 osc_clk = ~osc_clk;

    seq_muldiv #(.N(N)) dut (
        .clock       (osc_clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation and check the full timeline: busy t+1..t+N+1,
    // done at t+N+2 with the expected results, idle afterwards.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic [N-1:0] exp_lo, input logic [N-1:0] exp_hi,
                          input logic exp_dz);
        int unsigned bad_busy = 0;
        int unsigned bad_hold = 0;
        @(negedge osc_clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge osc_clk);
        start = 1'b0;
        for (int k = 1; k <= int'(N) + 1; k++) begin
            if (k > 1) @(negedge osc_clk);
            if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
            if (result_lo !== last_lo || result_hi !== last_hi) bad_hold++;
        end
        check({tag, " busy window"}, bad_busy, 0);
        check({tag, " result hold"}, bad_hold, 0);
        @(negedge osc_clk);
        check({tag, " done"}, {done, busy}, 2'b10);
        check({tag, " lo"}, result_lo, exp_lo);
        check({tag, " hi"}, result_hi, exp_hi);
        check({tag, " dz"}, div_by_zero, exp_dz);
        @(negedge osc_clk);
        check({tag, " done drop"}, {done, busy}, 2'b00);
        last_lo = exp_lo;
        last_hi = exp_hi;
    endtask

    initial begin
        int unsigned n;

        // Reset state
        repeat (2) @(negedge osc_clk);
        check("reset outputs", {busy, done, div_by_zero, result_lo, result_hi}, '0);
        reset = 1'b0;

        // Multiply
        run_op("mulu 200x150", 2'b00, 8'd200, 8'd150, 8'h30, 8'h75, 1'b0);
        run_op("muls -3x5",    2'b01, 8'hFD,  8'h05,  8'hF1, 8'hFF, 1'b0);
        run_op("muls -128^2",  2'b01, 8'h80,  8'h80,  8'h00, 8'h40, 1'b0);
        run_op("muls -128x1",  2'b01, 8'h80,  8'h01,  8'h80, 8'hFF, 1'b0);
        run_op("mulu ffxff",   2'b00, 8'hFF,  8'hFF,  8'h01, 8'hFE, 1'b0);

        // Divide
        run_op("divu 200/7",   2'b10, 8'd200, 8'd7,   8'h1C, 8'h04, 1'b0);
        run_op("divs -7/2",    2'b11, 8'hF9,  8'h02,  8'hFD, 8'hFF, 1'b0);
        run_op("divs 7/-2",    2'b11, 8'h07,  8'hFE,  8'hFD, 8'h01, 1'b0);
        run_op("divs ovf",     2'b11, 8'h80,  8'hFF,  8'h80, 8'h00, 1'b0);
        run_op("divs by 0",    2'b11, 8'h2A,  8'h00,  8'hFF, 8'h2A, 1'b1);
        run_op("mulu after dz",2'b00, 8'h01,  8'h01,  8'h01, 8'h00, 1'b0);
        run_op("divu by 0",    2'b10, 8'hC3,  8'h00,  8'hFF, 8'hC3, 1'b1);
        run_op("divu 255/16",  2'b10, 8'hFF,  8'h10,  8'h0F, 8'h0F, 1'b0);

        // Start during RUN is ignored
        @(negedge osc_clk);
        op = 2'b00; a = 8'd2; b = 8'd3; start = 1'b1;
        @(negedge osc_clk);                 // t+1
        start = 1'b0;
        repeat (2) @(negedge osc_clk);      // t+3
        a = 8'd5; b = 8'd5; start = 1'b1;
        @(negedge osc_clk);                 // t+4
        start = 1'b0;
        repeat (5) @(negedge osc_clk);      // t+9
        check("ignored start busy", {done, busy}, 2'b01);
        @(negedge osc_clk);                 // t+10
        check("ignored start done", {done, busy}, 2'b10);
        check("ignored start lo", result_lo, 8'h06);
        check("ignored start hi", result_hi, 8'h00);
        @(negedge osc_clk);

        // Back-to-back with start held high
        op = 2'b00; a = 8'd3; b = 8'd4; start = 1'b1;
        n = 0;
        do begin
            @(negedge osc_clk);
            n++;
        end while (done !== 1'b1 && n < 20);
        check("b2b first done", n, 10);
        for (int r = 0; r < 2; r++) begin
            n = 0;
            do begin
                @(negedge osc_clk);
                n++;
            end while (done !== 1'b1 && n < 20);
            check("b2b interval", n, 10);
        end
        check("b2b lo", result_lo, 8'h0C);
        start = 1'b0;
        repeat (12) @(negedge osc_clk);
        check("b2b idle", {done, busy}, 2'b00);

        // Reset mid-operation
        op = 2'b10; a = 8'd200; b = 8'd7; start = 1'b1;
        @(negedge osc_clk);                 // t+1
        start = 1'b0;
        repeat (3) @(negedge osc_clk);      // t+4
        reset = 1'b1;
        @(negedge osc_clk);                 // t+5
        check("mid reset outputs", {busy, done, div_by_zero, result_lo, result_hi}, '0);
        reset = 1'b0;
        @(negedge osc_clk);
        check("post reset idle", {done, busy}, 2'b00);
        last_lo = '0;
        last_hi = '0;
        run_op("after reset", 2'b10, 8'd200, 8'd7, 8'h1C, 8'h04, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
